// File: rtl/program_loader.sv
// Framed byte-stream loader: writes a program image into CPU RAM from address 0
// and holds the CPU in reset until a frame with a correct checksum has landed.
module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  input  logic                  halt_i,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [2:0]            dbg_state
);

  localparam int unsigned MEM_DEPTH = 2**ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;

  logic                  xfer;
  logic                  len_ok;
  logic [CW-1:0]         addr_inc;
  logic [DATA_WIDTH-1:0] sum_chk;

  // Handshake: a byte moves on a rising edge when rx_valid && rx_ready; the
  // upstream holds rx_data stable until then. While the CPU runs, rx_ready
  // follows halt_i so a reload can only start once the program has halted.
  assign rx_ready = (state_q == S_RUN) ? halt_i : 1'b1;
  assign xfer     = rx_valid && rx_ready;

  assign len_ok   = (rx_data != '0) && (32'(rx_data) <= MEM_DEPTH);
  assign addr_inc = addr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign sum_chk  = sum_q + rx_data;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    if (xfer) begin
      unique case (state_q)
        S_IDLE, S_RUN, S_ERROR: begin
          if (rx_data == SYNC_BYTE) state_d = S_LEN;
        end
        S_LEN: begin
          if (len_ok) begin
            len_d   = CW'(rx_data);
            addr_d  = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_ERROR;
          end
        end
        S_DATA: begin
          ram_we_d   = 1'b1;
          ram_addr_d = addr_q[ADDR_WIDTH-1:0];
          ram_data_d = rx_data;
          sum_d      = sum_chk;
          addr_d     = addr_inc;
          if (addr_inc == len_q) state_d = S_CHECK;
        end
        S_CHECK: begin
          state_d = (sum_chk == '0) ? S_RUN : S_ERROR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  // Status decodes straight from state so an async reset asserts cpu_reset at once.
  assign cpu_reset  = (state_q != S_RUN);
  assign load_done  = (state_q == S_RUN);
  assign load_error = (state_q == S_ERROR);
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign dbg_state  = state_q;

endmodule
